// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit bridging core access (req_valid/req_ready/mem_wr/mem_op/addr/wdata -> resp_valid/rdata/err) to a word bus (bus_valid/bus_ready/bus_we/bus_addr/bus_wstrb/bus_wdata/bus_rdata); LSU_MISALIGN_TRAP_EN traps misaligned accesses
module mem_lsu #(
  parameter int WIDTH = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             mem_wr,
  input  logic [2:0]       mem_op,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       err,
  output logic             bus_valid,
  input  logic             bus_ready,
  output logic             bus_we,
  output logic [WIDTH-1:0] bus_addr,
  output logic [3:0]       bus_wstrb,
  output logic [WIDTH-1:0] bus_wdata,
  input  logic [WIDTH-1:0] bus_rdata
);
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t st;
  logic [CW-1:0] cnt;
  logic wr;
  logic [2:0] op;
  logic [WIDTH-1:0] a, wd, r, aln, sh, ld;
  logic [1:0] e;
  logic bad, mis, sx;
  always_comb begin
    bad = mem_op[1:0] == 2'b11 || (mem_op[2] && (mem_op[1] || mem_wr));
    mis = (mem_op[1:0] == 2'b01 && addr[0]) || (mem_op[1:0] == 2'b10 && addr[1:0] != 2'b00);
    aln = {addr[WIDTH-1:2], mem_op[1] ? 2'b00 : {addr[1], addr[0] & ~mem_op[0]}};
    sh = bus_rdata >> {a[1:0], 3'b000};
    sx = ~op[2];
    ld = op[1:0] == 2'b00 ? {{24{sx & sh[7]}}, sh[7:0]} :
         op[1:0] == 2'b01 ? {{16{sx & sh[15]}}, sh[15:0]} : sh;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      wr <= 1'b0;
      op <= '0;
      a <= '0;
      wd <= '0;
      r <= '0;
      e <= '0;
    end else begin
      case (st)
        IDLE: if (req_valid) begin
          wr <= mem_wr;
          op <= mem_op;
          a <= aln;
          wd <= wdata;
          r <= '0;
          cnt <= '0;
          e <= bad ? 2'b10 : (TRAP && mis) ? 2'b01 : 2'b00;
          st <= (bad || (TRAP && mis)) ? RESP : BUS;
        end
        BUS: if (bus_ready) begin
          r <= wr ? '0 : ld;
          st <= RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          e <= 2'b11;
          st <= RESP;
        end else cnt <= cnt + 1'b1;
        default: st <= IDLE;
      endcase
    end
  end
  assign req_ready = st == IDLE;
  assign bus_valid = st == BUS;
  assign resp_valid = st == RESP;
  assign bus_we = bus_valid & wr;
  assign bus_addr = bus_valid ? {a[WIDTH-1:2], 2'b00} : '0;
  assign bus_wstrb = !bus_we ? 4'b0000 :
                     op[1:0] == 2'b00 ? 4'b0001 << a[1:0] :
                     op[1:0] == 2'b01 ? 4'b0011 << a[1:0] : 4'b1111;
  assign bus_wdata = !bus_valid ? '0 :
                     op[1:0] == 2'b00 ? {4{wd[7:0]}} :
                     op[1:0] == 2'b01 ? {2{wd[15:0]}} : wd;
  assign rdata = resp_valid ? r : '0;
  assign err = resp_valid ? e : 2'b00;
endmodule
